l1_spike_trace_encoder: RTL
===========================

Name: l1_spike_trace_encoder

Overview:
- Downstream consumer of the L1 spike output.
- Converts the 6-bit L1 spike vector into per-neuron decaying time-surface traces for the next layer.
- Buffers spike events, each tagged with the L1 local-attention flag, in a small FIFO. A valid/ready handshake delivers one event at a time to a serially-processing downstream layer.
- Sits between L1's o_spike_out/o_las and the next layer's event/trace inputs.

Parameters:
p_width, 9, trace fractional width; each trace is p_width+1 bits; full scale TMAX = 2**p_width
p_n, 6, number of L1 neurons (spike channels)
p_prescale, 16, clock cycles between decay steps; must be >= 1
p_decay_step, 4, amount subtracted from every trace per decay step
p_fifo_depth, 4, event FIFO entries; power of 2

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_spike  input  p_n  L1 spike vector, one-cycle pulses, bit k-1 = neuron k
i_las  input  1  L1 local-attention flag, sampled with i_spike
i_ready  input  1  downstream accepts head event this cycle
o_tr  output  p_n*(p_width+1)  live traces, channel k at bits [k*(p_width+1)-1 : (k-1)*(p_width+1)]
o_event  output  p_n  spike vector of FIFO head
o_las  output  1  attention tag of FIFO head
o_valid  output  1  FIFO non-empty
o_overflow  output  1  sticky: an event was dropped
o_level  output  clog2(p_fifo_depth)+1  FIFO occupancy

Behaviour:
- Reset (i_rst high at a clock edge):
  - all traces 0, prescaler 0, FIFO empty, o_valid 0, o_event 0, o_las 0, o_overflow 0, o_level 0.
  - Reset mid-operation discards buffered events. Inputs sampled in the reset cycle are ignored.
- Prescaler:
  - Counts 0..p_prescale-1 and wraps.
  - decay_tick is asserted in the cycle the count equals p_prescale-1.
- Trace update, per channel, every cycle. Priority is spike > decay > hold:
  - i_spike[k] = 1: trace_k <= TMAX.
  - else if decay_tick: trace_k <= trace_k - p_decay_step, saturating at 0 (no wrap; the compare is done at p_width+1 bits).
  - else: hold.
- Trace timing and width:
  - A spike at edge N is visible on o_tr after edge N, i.e. latency 1.
  - Traces never exceed TMAX; the MSB is set only at TMAX.
- Event capture:
  - When i_spike != 0, push {i_spike, i_las} into the FIFO at the same edge the traces update.
  - Simultaneous spikes form a single entry holding the full vector; they are not split.
  - i_spike == 0 never pushes.
- Handshake:
  - Pop when o_valid && i_ready. o_event/o_las present the head entry combinationally from FIFO storage.
  - The head holds stable while o_valid=1 and i_ready=0.
  - No bypass: an event pushed at edge N makes o_valid=1 after edge N, at the earliest.
  - i_ready while empty has no effect.
- Full FIFO:
  - Push with pop in the same cycle: both occur and the level is unchanged.
  - Push without pop: the new entry is dropped, o_overflow <= 1 (sticky until reset), the FIFO is unchanged, and the traces still update.
- Empty FIFO: o_valid=0, o_event=0, o_las=0.
- Pointers wrap modulo p_fifo_depth. Occupancy is tracked with an explicit count register.

Decomposition:
- Shared package (ODESA common): TMAX constant function, trace-slice index function, clog2. The fields p_width/p_n retain their L1 meaning.
- One natural sub-module: l1_event_fifo. It is a synchronous FIFO (width p_n+1, depth p_fifo_depth) with push/pop/full/empty/level, and implements the push+pop-when-full rule.
- The trace array and prescaler live in the top module.

Test Plan:
1. Reset then idle 100 cycles (p_prescale=16, p_decay_step=4) -> all o_tr 0, o_valid 0, o_overflow 0, o_level 0.
2. Single spike 6'b000100, i_las=1, i_ready=0:
   - channel 3 trace = 512 one cycle later.
   - After 16 cycles it reads 508, then 504, and so on.
   - o_valid=1, o_event=000100, o_las=1 held until i_ready; pop clears o_valid.
3. Spike on channel 1 in the same cycle as decay_tick -> trace = 512, not 508. A trace at 2 when decay ticks -> 0, not wrapped.
4. Simultaneous 6'b100001 -> one FIFO entry, o_level=1, both traces 512.
5. i_ready=0 with spikes on 5 consecutive cycles (depth 4):
   - o_level saturates at 4 and o_overflow=1.
   - A 6th spike arriving while i_ready=1 and full -> level stays 4, o_overflow remains 1, head advances in order.
6. Assert i_rst with 3 events queued and traces non-zero -> the next cycle shows everything zero. Spikes presented during reset are not captured.

Source files
------------

// File: rtl/l1_spike_trace_encoder_pkg.sv
// Shared ODESA helpers: full-scale trace value, trace slice offsets and clog2.
package l1_spike_trace_encoder_pkg;

  // Ceiling log2, usable in parameter and port-width expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Full-scale trace value for a given fractional width
  function automatic int tmax(input int width);
    return 1 << width;
  endfunction

  // Low bit of the slice holding neuron k (k counts from 1) in a packed trace bus
  function automatic int trace_lo(input int k, input int width);
    return (k - 1) * (width + 1);
  endfunction

endpackage

// File: rtl/l1_spike_trace_encoder_if.sv
// Event handshake between the trace encoder and the serial downstream layer.
interface l1_spike_trace_encoder_if #(
  parameter int p_n = 6
);
  logic [p_n-1:0] o_event;
  logic           o_las;
  logic           o_valid;
  logic           i_ready;

  modport master (output o_event, output o_las, output o_valid, input i_ready);
  modport slave  (input o_event, input o_las, input o_valid, output i_ready);
endinterface

// File: rtl/l1_event_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO only succeeds when a pop frees a slot.
module l1_event_fifo
  import l1_spike_trace_encoder_pkg::*;
#(
  parameter int p_data_width = 7,
  parameter int p_depth      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic [p_data_width-1:0] i_data,
  input  logic                    i_pop,
  output logic [p_data_width-1:0] o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_drop,
  output logic [clog2(p_depth):0] o_level
);

  localparam int AW = clog2(p_depth);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_V = LW'(p_depth);

  logic [p_data_width-1:0] mem [p_depth];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           count;
  logic                    do_push;
  logic                    do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == DEPTH_V);
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_drop  = i_push && o_full && !do_pop;
  assign o_data  = o_empty ? '0 : mem[rd_ptr];
  assign o_level = count;

  // Storage write; contents need no reset because the count masks stale entries
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l1_spike_trace_encoder.sv
// Turns L1 spikes into decaying time-surface traces and queues tagged spike events.
module l1_spike_trace_encoder
  import l1_spike_trace_encoder_pkg::*;
#(
  parameter int p_width      = 9,
  parameter int p_n          = 6,
  parameter int p_prescale   = 16,
  parameter int p_decay_step = 4,
  parameter int p_fifo_depth = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [p_n-1:0]               i_spike,
  input  logic                         i_las,
  output logic [p_n*(p_width+1)-1:0]   o_tr,
  output logic                         o_overflow,
  output logic [clog2(p_fifo_depth):0] o_level,
  l1_spike_trace_encoder_if.master     evt
);

  localparam int TW  = p_width + 1;
  localparam int PSW = (p_prescale > 1) ? clog2(p_prescale) : 1;
  localparam logic [TW-1:0]  TMAX_V  = TW'(tmax(p_width));
  localparam logic [TW-1:0]  STEP_V  = TW'(p_decay_step);
  localparam logic [PSW-1:0] PS_LAST = PSW'(p_prescale - 1);

  logic [PSW-1:0] presc;
  logic           decay_tick;
  logic [TW-1:0]  trace [p_n];
  logic [p_n:0]   head;
  logic           drop;

  assign decay_tick = (presc == PS_LAST);

  // Prescaler sets the decay rate: one decay step every p_prescale cycles
  always_ff @(posedge i_clk) begin
    if (i_rst)           presc <= '0;
    else if (decay_tick) presc <= '0;
    else                 presc <= presc + 1'b1;
  end

  // Per-neuron trace: a spike reloads full scale, a decay tick lowers it without wrapping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < p_n; k++) trace[k] <= '0;
    end else begin
      for (int k = 0; k < p_n; k++) begin
        if (i_spike[k])      trace[k] <= TMAX_V;
        else if (decay_tick) trace[k] <= (trace[k] >= STEP_V) ? trace[k] - STEP_V : '0;
      end
    end
  end

  // Pack the trace array onto the output bus, neuron 1 in the lowest slice
  for (genvar g = 0; g < p_n; g++) begin : g_tr
    assign o_tr[trace_lo(g + 1, p_width) +: TW] = trace[g];
  end

  l1_event_fifo #(
    .p_data_width(p_n + 1),
    .p_depth     (p_fifo_depth)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (|i_spike),
    .i_data ({i_spike, i_las}),
    .i_pop  (evt.i_ready),
    .o_data (head),
    .o_full (),
    .o_empty(),
    .o_drop (drop),
    .o_level(o_level)
  );

  assign evt.o_event = head[p_n:1];
  assign evt.o_las   = head[0];
  assign evt.o_valid = (o_level != '0);

  // Sticky record that at least one event was lost to a full FIFO
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_overflow <= 1'b0;
    else if (drop) o_overflow <= 1'b1;
  end

endmodule
